// File: rtl/pool_window_ctrl_if.sv
// rtl/pool_window_ctrl_if.sv - request, feature-memory read and window-flag signals of pool_window_ctrl
// master is the sequencer side; slave is the layer controller / memory / pooling side.
interface pool_window_ctrl_if #(
  parameter int AWIDTH = 10,
  parameter int OWIDTH = 6
);
  logic              req;
  logic [AWIDTH-1:0] base_addr;
  logic              ack;
  logic              read_en;
  logic [AWIDTH-1:0] read_addr;
  logic              buf_valid;
  logic [OWIDTH-1:0] out_addr;
  logic              done;

  modport master (
    input  req,
    input  base_addr,
    output ack,
    output read_en,
    output read_addr,
    output buf_valid,
    output out_addr,
    output done
  );

  modport slave (
    output req,
    output base_addr,
    input  ack,
    input  read_en,
    input  read_addr,
    input  buf_valid,
    input  out_addr,
    input  done
  );
endinterface

// File: rtl/pool_window_ctrl.sv
// rtl/pool_window_ctrl.sv - streams an FSIZE x FSIZE map into the 2x2 line buffer and flags stride-2 windows
// Window flags come only from the load counters, so stale line-buffer contents are never flagged.
module pool_window_ctrl #(
  parameter int FSIZE  = 12,
  parameter int AWIDTH = 10,
  parameter int OWIDTH = 6
) (
  input  logic                clk,
  input  logic                xrst,
  pool_window_ctrl_if.master  bus
);

  localparam int NPIX = FSIZE * FSIZE;
  localparam int IW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int CW   = (FSIZE > 1) ? $clog2(FSIZE) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [AWIDTH-1:0] r_base;
  logic [IW-1:0]     r_idx;
  logic              r_drain;
  logic              r_en_d1;
  logic              r_en_d2;
  logic [CW-1:0]     r_row;
  logic [CW-1:0]     r_col;
  logic [CW-1:0]     w_row_nxt;
  logic [CW-1:0]     w_col_nxt;
  logic              r_buf_valid;
  logic [OWIDTH-1:0] r_out_addr;
  logic              w_ack;
  logic              w_read_en;
  logic              w_done;
  logic              w_accept;
  logic              w_last_rd;

  assign w_accept  = w_ack & bus.req;
  assign w_last_rd = (r_idx == IW'(NPIX - 1));

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ack       = 1'b0;
    w_read_en   = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ack = 1'b1;
        if (bus.req) begin
          w_state_nxt = S_READ;
        end
      end
      S_READ: begin
        w_read_en = 1'b1;
        if (w_last_rd) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_drain) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // r_drain marks the second DRAIN cycle
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      r_base  <= '0;
      r_idx   <= '0;
      r_drain <= 1'b0;
    end else begin
      if (w_accept) begin
        r_base <= bus.base_addr;
        r_idx  <= '0;
      end else if (w_read_en) begin
        r_idx <= r_idx + IW'(1);
      end
      r_drain <= (r_state == S_DRAIN) ? ~r_drain : 1'b0;
    end
  end

  // Position of the pixel landing in the buffer this cycle, applied on the second delayed strobe
  always_comb begin
    w_row_nxt = r_row;
    w_col_nxt = r_col;
    if (r_en_d2) begin
      if (r_col == CW'(FSIZE - 1)) begin
        w_col_nxt = '0;
        w_row_nxt = (r_row == CW'(FSIZE - 1)) ? '0 : r_row + CW'(1);
      end else begin
        w_col_nxt = r_col + CW'(1);
      end
    end
  end

  // w_*_nxt during the bus cycle is the coordinate of the pixel on the bus, so the
  // registered flag rises exactly when that pixel becomes the newest one in the buffer.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      r_en_d1     <= 1'b0;
      r_en_d2     <= 1'b0;
      r_row       <= '0;
      r_col       <= '0;
      r_buf_valid <= 1'b0;
      r_out_addr  <= '0;
    end else begin
      r_en_d1     <= w_read_en;
      r_en_d2     <= r_en_d1;
      r_buf_valid <= r_en_d1 & w_row_nxt[0] & w_col_nxt[0];
      if (w_accept) begin
        r_row      <= '0;
        r_col      <= '0;
        r_out_addr <= '0;
      end else begin
        r_row <= w_row_nxt;
        r_col <= w_col_nxt;
        if (r_buf_valid) begin
          r_out_addr <= r_out_addr + OWIDTH'(1);
        end
      end
    end
  end

  assign bus.ack       = w_ack;
  assign bus.read_en   = w_read_en;
  assign bus.read_addr = r_base + AWIDTH'(r_idx);
  assign bus.buf_valid = r_buf_valid;
  assign bus.out_addr  = r_out_addr;
  assign bus.done      = w_done;

endmodule

// File: doc/pool_window_ctrl.md
# pool_window_ctrl

Sequencer for the 2x2 feature line buffer `linebuf_feat` (row length FSIZE, depth FSIZE+2). On a start request it streams one FSIZE x FSIZE feature map out of feature memory, one pixel per cycle, into the line buffer. It also flags the cycles in which `pixel_feat0..3` hold an aligned, stride-2 2x2 pooling window, and numbers each window for the pooling stage's output write. It sits between the layer controller (req/ack) and the feature memory / line buffer / pooling datapath.

## Interface
Parameters:
- FSIZE, 12: feature map width and height in pixels. Even, ≥2. Must equal the line buffer row length.
- AWIDTH, 10: feature memory address width.
- OWIDTH, 6: output window index width. Requires 2^OWIDTH ≥ (FSIZE/2)².

Ports:
- clk  in  1  single clock; all state updates on rising edge
- xrst  in  1  asynchronous, active-low reset
- req  in  1  start pulse; sampled only when ack=1
- base_addr  in  AWIDTH  first pixel address of the map; captured on the accepted req
- ack  out  1  1 = idle and ready; 0 = busy
- read_en  out  1  feature memory read strobe
- read_addr  out  AWIDTH  feature memory address, valid while read_en=1
- buf_valid  out  1  `pixel_feat0..3` of the line buffer form a valid window in this cycle
- out_addr  out  OWIDTH  index of the window flagged by buf_valid
- done  out  1  one-cycle pulse after the last window

## Operation
- Memory read latency is fixed at 1: data for the address issued in cycle t is on `read_data` in cycle t+1 and is inside the line buffer from cycle t+2.
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE: ack=1. On req=1, latch base_addr, clear all counters, go to READ.
  - READ: read_en=1, read_addr = base + i for i = 0 … FSIZE²−1, one address per cycle. After i = FSIZE²−1, go to DRAIN.
  - DRAIN: 2 cycles, read_en=0. Lets the last pixel reach the buffer and its window be flagged.
  - DONE: 1 cycle, done=1, then return to IDLE.
- Load tracking: read_en is delayed through two registers (issue → bus → buffer). Row and column counters (0 … FSIZE−1, column wrapping into row) advance on the second delayed strobe. They give the position of the newest pixel in the buffer.
- buf_valid is registered and is high in exactly those cycles where the newest buffered pixel has odd row and odd column. In that cycle `pixel_feat0..3` = (r−1,c−1), (r−1,c), (r,c−1), (r,c).
- out_addr starts at 0 and increments by 1 in the cycle after each buf_valid. It holds its final value until the next accepted req.
- Address arithmetic is modulo 2^AWIDTH; wrap-around past the top of memory is legal.
- req while ack=0 is ignored; nothing is queued.
- The line buffer has no reset. Its stale contents are never flagged, because buf_valid is derived only from the counters.

## Timing
- Reset values (asynchronous assert, immediate): state=IDLE, ack=1, read_en=0, read_addr=0, buf_valid=0, out_addr=0, done=0, all counters 0.
- Deasserting xrst mid-operation leaves the block in IDLE; no done pulse is produced for the aborted map.
- Cycle 0 = the first READ cycle, one cycle after req is sampled high in IDLE.
  - Reads occupy cycles 0 … FSIZE²−1.
  - DRAIN occupies cycles FSIZE² and FSIZE²+1.
  - done is high in cycle FSIZE²+2.
  - ack is high from cycle FSIZE²+3.
- The first buf_valid is in cycle FSIZE+3, from pixel (1,1), which is issued in cycle FSIZE+1.
- Within an odd row, buf_valid pulses every 2 cycles, FSIZE/2 times. The last pulse is in cycle FSIZE²+1.
- Total buf_valid pulses per map = (FSIZE/2)².
- Minimum request-to-request period = FSIZE²+4 cycles.

## Test plan
- Reset: assert xrst=0 mid-cycle → all outputs immediately at their reset values, ack=1; hold for 3 clocks with req=1 → no read_en.
- Nominal run, FSIZE=12, base_addr=0x040: read_addr 0x040…0x0CF over cycles 0–143. 36 buf_valid pulses, first at cycle 15, last at cycle 145, out_addr 0…35. done at cycle 146, ack=1 at cycle 147. Memory model data = address, with windows checked against the expected pixel quadruples.
- Address wrap: base_addr=0x3F0, AWIDTH=10 → read_addr sequence 0x3F0…0x3FF, 0x000…0x07F. Window count is still 36.
- Busy request: pulse req at cycles 10 and 146 → both ignored, exactly one done. req at cycle 147 → new run starts at cycle 148.
- Reset mid-run: xrst=0 at cycle 50 → read_en, buf_valid and done are 0 immediately; after release, ack=1 and no done. A fresh req afterwards runs a full, correct map.
- Back-to-back maps: req held high continuously → runs separated by exactly FSIZE²+4 cycles, and out_addr restarts at 0 for each map.
